debug_mem_bridge: RTL and testbench

//  Debug-bus target translating 32-bit debug commands into single memory accesses on a
//  16-bit SoC memory port. Sits downstream of debug_control on the shared tri-state debug
//  bus (bus_addr/bus_data/bus_available/bus_accepted) as a sibling of debug_example;

---
 rtl/debug_mem_bridge.sv | 121 ++++++++++++
 tb/tb_debug_mem_bridge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_mem_bridge.sv
// Debug-bus target: turns one 32-bit debug command into a single 16-bit memory access
// and answers with one status+data word on the shared tri-state debug bus.
module debug_mem_bridge #(
  parameter logic [7:0] ADDR    = 8'd2,
  parameter int         AW      = 14,
  parameter int         TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    bus_addr,
  inout  wire  [31:0]   bus_data,
  output logic          bus_available,
  output logic          bus_accepted,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic [15:0]   mem_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DECODE  = 3'd1;
  localparam logic [2:0] MEM     = 3'd2;
  localparam logic [2:0] SETTLE  = 3'd3;
  localparam logic [2:0] RESPOND = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  logic [2:0]    state;
  logic [31:0]   cmd;
  logic [15:0]   txn_cnt;
  logic [TW-1:0] tcnt;
  logic [1:0]    resp_status;
  logic [15:0]   resp_data;
  logic          selected;
  logic [31:0]   resp_word;

  assign selected  = (bus_addr == ADDR);
  assign resp_word = {resp_status, cmd[29:16], resp_data};

  // Everything facing the shared bus floats unless this target is selected.
  assign bus_data      = (selected && state == RESPOND) ? resp_word : 32'bz;
  assign bus_available = selected ? (state == RESPOND) : 1'bz;
  assign bus_accepted  = selected ? (state == DECODE)  : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      txn_cnt     <= '0;
      tcnt        <= '0;
      resp_status <= ST_OK;
      resp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (selected) begin
            cmd   <= bus_data;
            state <= DECODE;
          end
        end
        DECODE: begin
          tcnt <= '0;
          case (cmd[31:30])
            2'b00, 2'b01: begin
              mem_req   <= 1'b1;
              mem_we    <= cmd[30];
              mem_addr  <= cmd[16 +: AW];
              mem_wdata <= cmd[15:0];
              state     <= MEM;
            end
            2'b10: begin
              resp_status <= ST_OK;
              resp_data   <= txn_cnt;
              state       <= SETTLE;
            end
            default: begin
              resp_status <= ST_ILLEGAL;
              resp_data   <= '0;
              state       <= SETTLE;
            end
          endcase
        end
        MEM: begin
          tcnt <= tcnt + 1'b1;
          // A ready arriving on the limit cycle still wins over the abort.
          if (mem_ready) begin
            mem_req     <= 1'b0;
            resp_status <= ST_OK;
            resp_data   <= mem_we ? mem_wdata : mem_rdata;
            txn_cnt     <= txn_cnt + 16'd1;
            state       <= SETTLE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            mem_req     <= 1'b0;
            resp_status <= ST_TIMEOUT;
            resp_data   <= '0;
            state       <= SETTLE;
          end
        end
        // Idle cycle so debug_control has stopped driving bus_data before we do.
        SETTLE:  state <= RESPOND;
        RESPOND: state <= DONE;
        DONE: begin
          if (!selected) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_mem_bridge.sv
// Randomized bench for debug_mem_bridge: acts as debug_control and memory, and predicts
// every response word from the command rules with a plain transaction-count model.
module tb_debug_mem_bridge;
  localparam logic [7:0] ADDR = 8'd2;
  localparam int         TMO  = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bus_addr;
  wire  [31:0] bus_data;
  wire         bus_available;
  wire         bus_accepted;
  logic        mem_req, mem_we, mem_ready;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [31:0] host_data;
  logic        host_drive;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] cnt_m;

  assign bus_data = host_drive ? host_data : 32'bz;

  always #5 clk = ~clk;

  debug_mem_bridge #(.ADDR(ADDR), .AW(14), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_available(bus_available), .bus_accepted(bus_accepted),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // lat = MEM cycle on which memory answers; 0 = memory never answers.
  function automatic logic [31:0] predict(input logic [31:0] cmd, input int lat,
                                          input logic [15:0] rdata);
    case (cmd[31:30])
      2'b00:   return (lat == 0) ? {2'b01, cmd[29:16], 16'h0} : {2'b00, cmd[29:16], rdata};
      2'b01:   return (lat == 0) ? {2'b01, cmd[29:16], 16'h0} : {2'b00, cmd[29:0]};
      2'b10:   return {2'b00, cmd[29:16], cnt_m};
      default: return {2'b10, cmd[29:16], 16'h0};
    endcase
  endfunction

  task automatic do_cmd(input logic [31:0] cmd, input int lat, input logic [15:0] rdata,
                        input int hold);
    logic [31:0] exp, got;
    int          reqc, exp_reqc;
    bit          seen;
    exp      = predict(cmd, lat, rdata);
    exp_reqc = cmd[31] ? 0 : ((lat == 0) ? TMO : lat);
    got      = '0;
    reqc     = 0;
    seen     = 0;
    @(negedge clk);
    bus_addr = ADDR; host_data = cmd; host_drive = 1'b1;
    @(negedge clk);
    chk("accepted", {31'b0, bus_accepted}, 32'd1);
    host_drive = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (bus_available === 1'b1) begin
        got  = bus_data;
        seen = 1;
      end else if (mem_req === 1'b1) begin
        reqc++;
        chk("mem_we", {31'b0, mem_we}, {31'b0, cmd[30]});
        chk("mem_addr", {18'b0, mem_addr}, {18'b0, cmd[29:16]});
        if (cmd[30]) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, cmd[15:0]});
        mem_ready = (lat != 0 && reqc == lat);
        mem_rdata = mem_ready ? rdata : 16'($urandom);
      end else begin
        mem_ready = 1'b0;
      end
    end
    if (!seen) chk("avail_timeout", 32'd0, 32'd1);
    else       chk("resp", got, exp);
    chk("req_cycles", reqc, exp_reqc);
    @(negedge clk);
    chk("avail_pulse", {31'b0, bus_available === 1'b1}, 32'd0);
    // Stay selected after the response: no re-accept, no drive of bus_data.
    for (int h = 0; h < hold; h++) begin
      host_data = $urandom; host_drive = 1'b1;
      #1;
      chk("done_nodrive", bus_data, host_data);
      chk("done_noaccept", {31'b0, bus_accepted === 1'b1}, 32'd0);
      @(negedge clk);
    end
    host_drive = 1'b0;
    bus_addr   = 8'd0;
    @(negedge clk);
    if (!cmd[31] && lat != 0) cnt_m = cnt_m + 16'd1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] cmd;
    int          reqc;
    cnt_m = '0;
    rst = 1'b1; bus_addr = 8'd0; host_data = '0; host_drive = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    bus_addr = ADDR;
    #1;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_fields", {mem_we, mem_addr, mem_wdata}, 32'd0);
    chk("rst_acc", {31'b0, bus_accepted}, 32'd0);
    chk("rst_avail", {31'b0, bus_available}, 32'd0);
    @(negedge clk);
    rst = 1'b0; bus_addr = 8'd0;
    @(negedge clk);

    do_cmd(32'h4012_ABCD, 2, 16'h0, 0);
    do_cmd(32'h8000_0000, 1, 16'h0, 0);
    do_cmd(32'h0012_0000, 1, 16'h5A5A, 0);
    do_cmd(32'h0012_0000, 0, 16'h0, 0);
    do_cmd(32'hC000_0000, 1, 16'h0, 0);
    do_cmd(32'h0123_4567, TMO, 16'h1357, 0);

    // Preload the counter so the 16-bit wrap is reachable in a short run.
    force dut.txn_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.txn_cnt;
    cnt_m = 16'hFFFE;
    do_cmd(32'h4001_0001, 3, 16'h0, 0);
    do_cmd(32'h8000_0000, 1, 16'h0, 0);
    do_cmd(32'h0002_0000, 1, 16'hBEEF, 0);
    do_cmd(32'h8000_0000, 1, 16'h0, 20);

    // Deselect mid-access: access still completes, response is never driven.
    cmd = 32'h4033_1234;
    reqc = 0;
    @(negedge clk);
    bus_addr = ADDR; host_data = cmd; host_drive = 1'b1;
    @(negedge clk);
    chk("abandon_acc", {31'b0, bus_accepted}, 32'd1);
    host_drive = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) reqc++;
      mem_ready = (mem_req === 1'b1 && reqc == 4);
      if (reqc >= 2) begin
        bus_addr = 8'd1; host_data = $urandom; host_drive = 1'b1;
        #1;
        chk("abandon_nodrive", bus_data, host_data);
        chk("abandon_noavail", {31'b0, bus_available === 1'b1}, 32'd0);
        chk("abandon_noacc", {31'b0, bus_accepted === 1'b1}, 32'd0);
      end
    end
    chk("abandon_reqc", reqc, 32'd4);
    host_drive = 1'b0; bus_addr = 8'd0; mem_ready = 1'b0;
    cnt_m = cnt_m + 16'd1;
    @(negedge clk);
    do_cmd(32'h8000_0000, 1, 16'h0, 0);

    // Reset while the memory access is outstanding.
    @(negedge clk);
    bus_addr = ADDR; host_data = 32'h0055_0000; host_drive = 1'b1;
    @(negedge clk);
    host_drive = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    rst = 1'b1; bus_addr = 8'd0;
    @(negedge clk);
    chk("rst_mid_req", {31'b0, mem_req}, 32'd0);
    rst = 1'b0;
    cnt_m = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_req", {31'b0, mem_req}, 32'd0);
    end
    do_cmd(32'h8000_0000, 1, 16'h0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      int          lat;
      op  = 2'($urandom_range(0, 3));
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      cmd = {op, 14'($urandom), 16'($urandom)};
      do_cmd(cmd, lat, 16'($urandom), (i % 8 == 0) ? 3 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
